// File: rtl/div_iter_if.sv
// Handshake/operand bundle between the EX stage and the iterative divider.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               annul_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;
  logic               div_zero_o;

  modport master (
    output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o, div_zero_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o, div_zero_o
  );
endinterface

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider producing {remainder, quotient}
// for the HI/LO pair. Works on magnitudes and fixes up signs when the
// result is registered on entry to END.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 7
) (
  input logic      clk,
  input logic      rst,
  div_iter_if.slave dif
);
  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] work;     // {partial remainder, dividend/quotient}
  logic [WIDTH-1:0] divisor;    // divisor magnitude
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0]   op1_mag, op2_mag;
  logic [2*WIDTH:0]   shifted;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] work_nxt;
  logic [WIDTH-1:0]   q_raw, r_raw, q_fix, r_fix;

  // Operand magnitudes and one restoring step on the working register
  always_comb begin
    op1_mag  = (dif.signed_i && dif.opdata1_i[WIDTH-1]) ? (~dif.opdata1_i + ONE) : dif.opdata1_i;
    op2_mag  = (dif.signed_i && dif.opdata2_i[WIDTH-1]) ? (~dif.opdata2_i + ONE) : dif.opdata2_i;
    shifted  = {work, 1'b0};
    ge       = shifted[2*WIDTH:WIDTH] >= {1'b0, divisor};
    // True difference is below the divisor, so W bits hold it exactly
    diff     = shifted[2*WIDTH-1:WIDTH] - divisor;
    work_nxt = ge ? {diff, shifted[WIDTH-1:1], 1'b1} : shifted[2*WIDTH-1:0];
    q_raw    = work_nxt[WIDTH-1:0];
    r_raw    = work_nxt[2*WIDTH-1:WIDTH];
    q_fix    = neg_q ? (~q_raw + ONE) : q_raw;
    r_fix    = neg_r ? (~r_raw + ONE) : r_raw;
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      work           <= '0;
      divisor        <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      dif.result_o   <= '0;
      dif.ready_o    <= 1'b0;
      dif.busy_o     <= 1'b0;
      dif.div_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dif.start_i && !dif.annul_i) begin
            divisor    <= op2_mag;
            work       <= {{WIDTH{1'b0}}, op1_mag};
            neg_q      <= dif.signed_i && (dif.opdata1_i[WIDTH-1] ^ dif.opdata2_i[WIDTH-1]);
            neg_r      <= dif.signed_i && dif.opdata1_i[WIDTH-1];
            cnt        <= '0;
            dif.busy_o <= 1'b1;
            state      <= (dif.opdata2_i == '0) ? DIVZERO : ON;
          end
        end
        DIVZERO: begin
          dif.busy_o <= 1'b0;
          if (dif.annul_i) begin
            state <= IDLE;
          end else begin
            state          <= END;
            dif.result_o   <= '0;
            dif.ready_o    <= 1'b1;
            dif.div_zero_o <= 1'b1;
          end
        end
        ON: begin
          if (dif.annul_i) begin
            dif.busy_o <= 1'b0;
            state      <= IDLE;
          end else begin
            work <= work_nxt;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
              dif.busy_o   <= 1'b0;
              dif.result_o <= {r_fix, q_fix};
              dif.ready_o  <= 1'b1;
              state        <= END;
            end
          end
        end
        END: begin
          if (dif.annul_i || !dif.start_i) begin
            state          <= IDLE;
            dif.result_o   <= '0;
            dif.ready_o    <= 1'b0;
            dif.div_zero_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: a 32-bit instance for the main scenarios and
// an 8-bit instance for narrow-width boundary vectors.
module tb_div_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(32)) dif ();
  div_iter_if #(.WIDTH(8))  dif8 ();

  div_iter #(.WIDTH(32), .CNT_W(7)) dut   (.clk(clk), .rst(rst), .dif(dif));
  div_iter #(.WIDTH(8),  .CNT_W(4)) dut8  (.clk(clk), .rst(rst), .dif(dif8));

  // Run one 32-bit division holding start until ready, then release it.
  task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output int lat, output logic dz,
                       output int busy_cnt, output logic rdy_after, output logic [63:0] res_after);
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = s; dif.opdata1_i = a; dif.opdata2_i = b;
    lat = 0; busy_cnt = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (dif.busy_o) busy_cnt++;
    end while (!dif.ready_o && lat < 100);
    res = dif.result_o; dz = dif.div_zero_o;
    @(negedge clk); dif.start_i = 1'b0;
    @(posedge clk); #1;
    rdy_after = dif.ready_o; res_after = dif.result_o;
  endtask

  // Same for the 8-bit instance, holding start one extra cycle in END.
  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] res, output int lat, output int busy_cnt,
                      output logic rdy_hold, output logic [15:0] res_hold);
    @(negedge clk);
    dif8.start_i = 1'b1; dif8.signed_i = s; dif8.opdata1_i = a; dif8.opdata2_i = b;
    lat = 0; busy_cnt = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (dif8.busy_o) busy_cnt++;
    end while (!dif8.ready_o && lat < 40);
    res = dif8.result_o;
    @(posedge clk); #1;
    rdy_hold = dif8.ready_o; res_hold = dif8.result_o;
    @(negedge clk); dif8.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (dif.result_o !== 64'd0) begin fails++; $display("FAIL reset_result got=%h exp=0", dif.result_o); end
    tests++; if ({dif.ready_o, dif.busy_o, dif.div_zero_o} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b exp=000", {dif.ready_o, dif.busy_o, dif.div_zero_o}); end
    tests++; if ({dif8.ready_o, dif8.busy_o, dif8.result_o} !== 18'd0) begin fails++; $display("FAIL reset_w8 got=%h exp=0", {dif8.ready_o, dif8.busy_o, dif8.result_o}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_divu();
    logic [63:0] r, ra; int lat, bc; logic dz, rdy;
    run32(1'b0, 32'd100, 32'd7, r, lat, dz, bc, rdy, ra);
    tests++; if (r !== {32'd2, 32'd14}) begin fails++; $display("FAIL divu_100_7 got=%h exp=%h", r, {32'd2, 32'd14}); end
    tests++; if (lat !== 33) begin fails++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    tests++; if (dz !== 1'b0) begin fails++; $display("FAIL divu_dz got=%b exp=0", dz); end
    tests++; if (bc !== 32) begin fails++; $display("FAIL divu_busy_cycles got=%0d exp=32", bc); end
    tests++; if (rdy !== 1'b0 || ra !== 64'd0) begin fails++; $display("FAIL divu_release got=%b/%h exp=0/0", rdy, ra); end
    run32(1'b0, 32'hFFFF_FFFF, 32'd1, r, lat, dz, bc, rdy, ra);
    tests++; if (r !== {32'd0, 32'hFFFF_FFFF}) begin fails++; $display("FAIL divu_max_1 got=%h exp=%h", r, {32'd0, 32'hFFFF_FFFF}); end
    run32(1'b0, 32'd5, 32'd9, r, lat, dz, bc, rdy, ra);
    tests++; if (r !== {32'd5, 32'd0}) begin fails++; $display("FAIL divu_5_9 got=%h exp=%h", r, {32'd5, 32'd0}); end
    run32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, dz, bc, rdy, ra);
    tests++; if (r !== {32'h8000_0000, 32'd0}) begin fails++; $display("FAIL divu_big got=%h exp=%h", r, {32'h8000_0000, 32'd0}); end
  endtask

  task automatic test_div_signed();
    logic [63:0] r, ra; int lat, bc; logic dz, rdy;
    run32(1'b1, 32'hFFFF_FFF9, 32'd2, r, lat, dz, bc, rdy, ra);
    tests++; if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin fails++; $display("FAIL div_m7_2 got=%h exp=%h", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
    run32(1'b1, 32'd7, 32'hFFFF_FFFE, r, lat, dz, bc, rdy, ra);
    tests++; if (r !== {32'd1, 32'hFFFF_FFFD}) begin fails++; $display("FAIL div_7_m2 got=%h exp=%h", r, {32'd1, 32'hFFFF_FFFD}); end
    run32(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, r, lat, dz, bc, rdy, ra);
    tests++; if (r !== {32'hFFFF_FFFF, 32'd3}) begin fails++; $display("FAIL div_m7_m2 got=%h exp=%h", r, {32'hFFFF_FFFF, 32'd3}); end
    tests++; if (lat !== 33) begin fails++; $display("FAIL div_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_overflow();
    logic [63:0] r, ra; int lat, bc; logic dz, rdy;
    run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, dz, bc, rdy, ra);
    tests++; if (r !== {32'd0, 32'h8000_0000}) begin fails++; $display("FAIL div_overflow got=%h exp=%h", r, {32'd0, 32'h8000_0000}); end
    tests++; if (dz !== 1'b0) begin fails++; $display("FAIL div_overflow_dz got=%b exp=0", dz); end
  endtask

  task automatic test_div_zero();
    logic [63:0] r, ra; int lat, bc; logic dz, rdy;
    run32(1'b0, 32'd1234, 32'd0, r, lat, dz, bc, rdy, ra);
    tests++; if (lat !== 2) begin fails++; $display("FAIL dz_latency got=%0d exp=2", lat); end
    tests++; if (r !== 64'd0) begin fails++; $display("FAIL dz_result got=%h exp=0", r); end
    tests++; if (dz !== 1'b1) begin fails++; $display("FAIL dz_flag got=%b exp=1", dz); end
    tests++; if (bc !== 1) begin fails++; $display("FAIL dz_busy_cycles got=%0d exp=1", bc); end
    tests++; if (rdy !== 1'b0 || dif.div_zero_o !== 1'b0) begin fails++; $display("FAIL dz_release got=%b/%b exp=0/0", rdy, dif.div_zero_o); end
    run32(1'b1, 32'hFFFF_FF00, 32'd0, r, lat, dz, bc, rdy, ra);
    tests++; if ({r, dz} !== {64'd0, 1'b1}) begin fails++; $display("FAIL dz_signed got=%h/%b exp=0/1", r, dz); end
  endtask

  task automatic test_annul();
    logic [63:0] r, ra; int lat, bc; logic dz, rdy; int seen;
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd1000; dif.opdata2_i = 32'd3;
    for (int i = 0; i < 10; i++) @(posedge clk);
    @(negedge clk); dif.annul_i = 1'b1; dif.start_i = 1'b0;
    @(posedge clk); #1;
    tests++; if ({dif.busy_o, dif.ready_o} !== 2'b00) begin fails++; $display("FAIL annul_on got=%b exp=00", {dif.busy_o, dif.ready_o}); end
    @(negedge clk); dif.annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (dif.ready_o || dif.busy_o) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL annul_quiet got=%0d exp=0", seen); end
    run32(1'b0, 32'd9, 32'd3, r, lat, dz, bc, rdy, ra);
    tests++; if (r !== {32'd0, 32'd3}) begin fails++; $display("FAIL annul_then_9_3 got=%h exp=%h", r, {32'd0, 32'd3}); end
    tests++; if (lat !== 33) begin fails++; $display("FAIL annul_then_latency got=%0d exp=33", lat); end
    // Annul while in END with start still high, then annul blocks a start in IDLE
    @(negedge clk); dif.start_i = 1'b1; dif.opdata1_i = 32'd50; dif.opdata2_i = 32'd0;
    for (int i = 0; i < 2; i++) @(posedge clk);
    #1;
    tests++; if (dif.ready_o !== 1'b1) begin fails++; $display("FAIL annul_end_setup got=%b exp=1", dif.ready_o); end
    @(negedge clk); dif.annul_i = 1'b1;
    @(posedge clk); #1;
    tests++; if ({dif.ready_o, dif.div_zero_o, dif.result_o} !== 66'd0) begin fails++; $display("FAIL annul_end got=%b%b/%h exp=0", dif.ready_o, dif.div_zero_o, dif.result_o); end
    @(posedge clk); #1;
    tests++; if ({dif.busy_o, dif.ready_o} !== 2'b00) begin fails++; $display("FAIL annul_idle got=%b exp=00", {dif.busy_o, dif.ready_o}); end
    @(negedge clk); dif.annul_i = 1'b0; dif.start_i = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd100; dif.opdata2_i = 32'd7;
    for (int i = 0; i < 3; i++) @(posedge clk);
    @(negedge clk); dif.opdata1_i = 32'd9; dif.opdata2_i = 32'd3; dif.signed_i = 1'b1;
    for (int i = 0; i < 30; i++) @(posedge clk);
    #1;
    tests++; if ({dif.ready_o, dif.result_o} !== {1'b1, 32'd2, 32'd14}) begin fails++; $display("FAIL ignore_midop got=%b/%h exp=1/%h", dif.ready_o, dif.result_o, {32'd2, 32'd14}); end
    @(negedge clk); dif.start_i = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd1000; dif.opdata2_i = 32'd3;
    for (int i = 0; i < 5; i++) @(posedge clk);
    @(negedge clk); rst = 1'b1; dif.start_i = 1'b0;
    @(posedge clk); #1;
    tests++; if ({dif.busy_o, dif.ready_o, dif.div_zero_o, dif.result_o} !== 67'd0) begin fails++; $display("FAIL reset_mid got=%b%b%b/%h exp=0", dif.busy_o, dif.ready_o, dif.div_zero_o, dif.result_o); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (dif.busy_o !== 1'b0) begin fails++; $display("FAIL reset_mid_idle got=%b exp=0", dif.busy_o); end
  endtask

  task automatic test_w8();
    logic [15:0] r, rh; int lat, bc; logic rdy;
    logic        sv [8];
    logic [7:0]  av [8];
    logic [7:0]  bv [8];
    logic [15:0] ev [8];
    sv[0]=1'b0; av[0]=8'd200; bv[0]=8'd7;   ev[0]={8'd4,   8'd28};
    sv[1]=1'b0; av[1]=8'd255; bv[1]=8'd1;   ev[1]={8'd0,   8'd255};
    sv[2]=1'b1; av[2]=8'h80;  bv[2]=8'hFF;  ev[2]={8'd0,   8'h80};
    sv[3]=1'b1; av[3]=8'h80;  bv[3]=8'h01;  ev[3]={8'd0,   8'h80};
    sv[4]=1'b1; av[4]=8'h7F;  bv[4]=8'h80;  ev[4]={8'h7F,  8'h00};
    sv[5]=1'b1; av[5]=8'h9C;  bv[5]=8'd7;   ev[5]={8'hFE,  8'hF2};
    sv[6]=1'b1; av[6]=8'h80;  bv[6]=8'h80;  ev[6]={8'd0,   8'd1};
    sv[7]=1'b0; av[7]=8'h80;  bv[7]=8'h80;  ev[7]={8'd0,   8'd1};
    for (int i = 0; i < 8; i++) begin
      run8(sv[i], av[i], bv[i], r, lat, bc, rdy, rh);
      tests++; if (r !== ev[i]) begin fails++; $display("FAIL w8_vec%0d got=%h exp=%h", i, r, ev[i]); end
      tests++; if (lat !== 9) begin fails++; $display("FAIL w8_latency%0d got=%0d exp=9", i, lat); end
      tests++; if (bc !== 8) begin fails++; $display("FAIL w8_busy%0d got=%0d exp=8", i, bc); end
      tests++; if (rdy !== 1'b1 || rh !== ev[i]) begin fails++; $display("FAIL w8_hold%0d got=%b/%h exp=1/%h", i, rdy, rh, ev[i]); end
    end
  endtask

  initial begin
    dif.start_i = 1'b0; dif.annul_i = 1'b0; dif.signed_i = 1'b0; dif.opdata1_i = '0; dif.opdata2_i = '0;
    dif8.start_i = 1'b0; dif8.annul_i = 1'b0; dif8.signed_i = 1'b0; dif8.opdata1_i = '0; dif8.opdata2_i = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_divu();
    test_div_signed();
    test_overflow();
    test_div_zero();
    test_annul();
    test_ignore_start();
    test_reset_mid();
    test_w8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
